// File: rtl/modsq_carry_normalizer.sv
// modsq_carry_normalizer
// Converts the squarer's redundant coefficient vector (17 significant bits per
// 32-bit slot) into a plain binary integer by rippling carries LANES
// coefficients per cycle. Result words and the left-over carry are held until
// the consumer takes them.
module modsq_carry_normalizer #(
    parameter int MOD_LEN            = 1024,
    parameter int WORD_LEN           = 16,
    parameter int REDUNDANT_ELEMENTS = 2,
    parameter int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
    parameter int COEFF_BITS         = 17,
    parameter int LANES              = 4,
    parameter int N_STEPS            = (NUM_ELEMENTS + LANES - 1) / LANES
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_ELEMENTS*2*WORD_LEN-1:0] sq_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_ELEMENTS*WORD_LEN-1:0] sq_out,
    output logic [1:0]                       carry_out
);

    localparam int SLOT_BITS = 2 * WORD_LEN;
    localparam int PAD_LEN   = N_STEPS * LANES;
    localparam int SUM_W     = WORD_LEN + 2;
    localparam int STEP_W    = $clog2(N_STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [STEP_W-1:0]     step_q;
    logic [1:0]            carry_q;
    logic [1:0]            carry_d;
    logic [1:0]            carry_out_q;
    logic [COEFF_BITS-1:0] coeff_q   [PAD_LEN];
    logic [COEFF_BITS-1:0] cap       [PAD_LEN];
    logic [COEFF_BITS-1:0] shift_src [PAD_LEN];
    logic [WORD_LEN-1:0]   words_q   [NUM_ELEMENTS];
    logic [WORD_LEN-1:0]   lane_word [LANES];
    logic [LANES-1:0]      lane_live;
    logic [NUM_ELEMENTS-1:0] slot_unused_bits;

    logic accept;
    logic run_step;
    logic run_last;

    assign accept   = (state_q == S_IDLE) && in_valid && in_ready_q;
    assign run_step = (state_q == S_RUN) && (step_q != STEP_W'(N_STEPS));
    assign run_last = (state_q == S_RUN) && (step_q == STEP_W'(N_STEPS));

    // Per-slot capture value and shift source; padding entries beyond the last
    // real coefficient read as zero.
    for (genvar g = 0; g < PAD_LEN; g++) begin : g_slot
        if (g < NUM_ELEMENTS) begin : g_real
            assign cap[g] = sq_in[g*SLOT_BITS +: COEFF_BITS];
            // Upper slot bits are deliberately ignored; fold them into a sink.
            assign slot_unused_bits[g] =
                ^sq_in[g*SLOT_BITS+COEFF_BITS +: SLOT_BITS-COEFF_BITS];
        end else begin : g_pad
            assign cap[g] = '0;
        end
        if (g + LANES < PAD_LEN) begin : g_shift
            assign shift_src[g] = coeff_q[g+LANES];
        end else begin : g_shift_end
            assign shift_src[g] = '0;
        end
    end

    // State register plus registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (run_last) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs, decoded from the next state so they are registered.
    always_comb begin
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // Step counter and running carry for the current pass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_q      <= '0;
            carry_q     <= '0;
            carry_out_q <= '0;
        end else if (accept) begin
            step_q  <= '0;
            carry_q <= '0;
        end else if (run_step) begin
            step_q  <= step_q + STEP_W'(1);
            carry_q <= carry_d;
        end else if (run_last) begin
            carry_out_q <= carry_q;
        end
    end

    // Coefficient window: captured on acceptance, shifted down by LANES per step.
    always_ff @(posedge clk) begin
        // NOTE: the coefficient store has no reset; it is always loaded on
        // acceptance before any step reads it.
        if (accept) begin
            coeff_q <= cap;
        end else if (run_step) begin
            coeff_q <= shift_src;
        end
    end

    // Carry chain across the LANES coefficients of the current step. Padding
    // lanes are skipped so the carry out of the top coefficient reaches
    // carry_out unchanged.
    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [1:0]       c;
        c = carry_q;
        for (int i = 0; i < LANES; i++) begin
            lane_live[i] = (int'(step_q) * LANES + i) < NUM_ELEMENTS;
            sum          = SUM_W'(coeff_q[i]) + SUM_W'(c);
            lane_word[i] = sum[WORD_LEN-1:0];
            if (lane_live[i]) begin
                c = sum[SUM_W-1:WORD_LEN];
            end
        end
        carry_d = c;
    end

    // Result words: each word is written only by the step that owns it.
    for (genvar g = 0; g < NUM_ELEMENTS; g++) begin : g_word
        localparam int STEP_OF = g / LANES;
        localparam int LANE_OF = g % LANES;

        // Word g register.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                words_q[g] <= '0;
            end else if (run_step && (step_q == STEP_W'(STEP_OF))) begin
                words_q[g] <= lane_word[LANE_OF];
            end
        end

        assign sq_out[g*WORD_LEN +: WORD_LEN] = words_q[g];
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign carry_out = carry_out_q;

endmodule

// File: tb/tb_modsq_carry_normalizer.sv
// Self-checking bench for modsq_carry_normalizer. Expected results come from
// treating the coefficient vector as an integer sum(coeff[j] * 2^(16j)).
module tb_modsq_carry_normalizer;

    localparam int NUM   = 66;
    localparam int WL    = 16;
    localparam int LAT   = 18;
    localparam int ACC_W = NUM * WL + 4;

    logic                  clk;
    logic                  reset_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [NUM*2*WL-1:0]   sq_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [NUM*WL-1:0]     sq_out;
    logic [1:0]            carry_out;

    logic [16:0]           coef  [NUM];
    logic [WL-1:0]         exp_w [NUM];
    logic [1:0]            exp_carry;
    logic [NUM*WL-1:0]     exp_sq;
    int                    n_checks = 0;
    int                    n_fail   = 0;
    int                    lat;

    modsq_carry_normalizer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sq_in     (sq_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sq_out    (sq_out),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pack coef[] into slots; upper bits get the given garbage pattern or random.
    task automatic drive_coefs(input bit rand_upper, input logic [14:0] upper);
        for (int j = 0; j < NUM; j++) begin
            logic [14:0] u;
            u = rand_upper ? 15'($urandom) : upper;
            sq_in[j*32 +: 32] = {u, coef[j]};
        end
    endtask

    // Reference: the normalized value is just the integer sum.
    task automatic run_model();
        logic [ACC_W-1:0] acc;
        acc = '0;
        for (int j = 0; j < NUM; j++) begin
            acc = acc + (ACC_W'(coef[j]) << (WL * j));
        end
        for (int j = 0; j < NUM; j++) begin
            exp_w[j] = acc[WL*j +: WL];
        end
        exp_sq    = acc[NUM*WL-1:0];
        exp_carry = acc[NUM*WL +: 2];
    endtask

    task automatic do_accept(input string tag);
        int n;
        n = 0;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_ready_wait"}, 32'(n < 50), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        lat = 0;
        while (!out_valid && lat < 40) begin
            check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    endtask

    task automatic check_result(input string tag);
        for (int j = 0; j < NUM; j++) begin
            check($sformatf("%s_word%0d", tag, j), 32'(sq_out[WL*j +: WL]), 32'(exp_w[j]));
        end
        check({tag, "_carry"}, 32'(carry_out), 32'(exp_carry));
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic full_pass(input string tag);
        run_model();
        do_accept(tag);
        wait_out(tag);
        check_result(tag);
        handoff(tag);
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sq_in     = '0;
        reset_n   = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_sq_zero", 32'(sq_out == '0), 32'd1);
        tick();
        tick();
        reset_n = 1'b1;
        check("rst_in_ready_held", 32'(in_ready), 32'd0);
        tick();
        check("rst_in_ready_rise", 32'(in_ready), 32'd1);

        // All-zero input.
        for (int j = 0; j < NUM; j++) coef[j] = '0;
        drive_coefs(1'b0, 15'h0);
        full_pass("zero");

        // Every coefficient at its maximum.
        for (int j = 0; j < NUM; j++) coef[j] = 17'h1FFFF;
        drive_coefs(1'b0, 15'h0);
        run_model();
        do_accept("max");
        wait_out("max");
        check_result("max");
        check("max_w0_const", 32'(sq_out[15:0]), 32'h0000_FFFF);
        check("max_w1_const", 32'(sq_out[31:16]), 32'h0);
        check("max_w65_const", 32'(sq_out[65*16 +: 16]), 32'h1);
        check("max_carry_const", 32'(carry_out), 32'd2);
        handoff("max");

        // Carry ripples through every lane and step.
        coef[0] = 17'h10000;
        for (int j = 1; j < NUM; j++) coef[j] = 17'h0FFFF;
        drive_coefs(1'b0, 15'h0);
        run_model();
        do_accept("ripple");
        wait_out("ripple");
        check_result("ripple");
        check("ripple_zero_const", 32'(sq_out == '0), 32'd1);
        check("ripple_carry_const", 32'(carry_out), 32'd1);
        handoff("ripple");

        // Upper slot garbage must be ignored.
        for (int j = 0; j < NUM; j++) coef[j] = 17'(j);
        drive_coefs(1'b0, 15'h7FFF);
        full_pass("garbage");

        // Random coefficients with random upper bits.
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < NUM; j++) coef[j] = 17'($urandom);
            drive_coefs(1'b1, 15'h0);
            full_pass($sformatf("rand%0d", r));
        end

        // Backpressure: hold the result while the producer churns.
        for (int j = 0; j < NUM; j++) coef[j] = 17'($urandom);
        drive_coefs(1'b1, 15'h0);
        run_model();
        do_accept("bp");
        wait_out("bp");
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'($urandom);
            for (int j = 0; j < NUM; j++) sq_in[j*32 +: 32] = $urandom;
            tick();
            check("bp_stable", 32'(sq_out === exp_sq), 32'd1);
            check("bp_carry_stable", 32'(carry_out), 32'(exp_carry));
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_valid_held", 32'(out_valid), 32'd1);
        end
        // Next input is presented on the handoff edge; it must not be taken there.
        for (int j = 0; j < NUM; j++) coef[j] = 17'($urandom);
        drive_coefs(1'b1, 15'h0);
        run_model();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_handoff_valid", 32'(out_valid), 32'd0);
        check("bp_handoff_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        wait_out("bp_next");
        check_result("bp_next");
        handoff("bp_next");

        // Reset in the middle of RUN.
        for (int j = 0; j < NUM; j++) coef[j] = 17'($urandom) | 17'h1;
        drive_coefs(1'b1, 15'h0);
        do_accept("mid");
        for (int s = 0; s < 8; s++) tick();
        check("mid_busy", 32'(in_ready), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_sq", 32'(sq_out == '0), 32'd1);
        check("mid_rst_carry", 32'(carry_out), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mid_rst_no_valid", 32'(out_valid), 32'd0);
        end
        reset_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            tick();
            check("mid_post_no_valid", 32'(out_valid), 32'd0);
        end
        for (int j = 0; j < NUM; j++) coef[j] = '0;
        drive_coefs(1'b0, 15'h0);
        full_pass("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
